// File: rtl/ct_ifu_rst_inv_seq.sv
// Reset-time invalidation sequencer: walks every icache tag set and BHT entry
// once per start pulse, then holds done until the next pulse.
module ct_ifu_rst_inv_seq #(
  parameter int IC_IDX_W  = 8,
  parameter int BHT_IDX_W = 10
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 ifu_cp0_rst_inv_req,
  input  logic                 icache_inv_grant,
  input  logic                 bht_inv_grant,
  output logic                 inv_icache_tag_req,
  output logic [IC_IDX_W-1:0]  inv_icache_idx,
  output logic                 inv_bht_req,
  output logic [BHT_IDX_W-1:0] inv_bht_idx,
  output logic                 cp0_ifu_rst_inv_done,
  output logic                 inv_busy
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    INV  = 3'b010,
    DONE = 3'b100
  } state_e;

  state_e               state_q, state_d;
  logic [IC_IDX_W-1:0]  ic_cnt_q, ic_cnt_d;
  logic [BHT_IDX_W-1:0] bht_cnt_q, bht_cnt_d;
  logic                 ic_fin_q, ic_fin_d;
  logic                 bht_fin_q, bht_fin_d;
  logic                 done_q, done_d;
  logic                 ic_acc, bht_acc;

  assign ic_acc  = (state_q == INV) && !ic_fin_q && icache_inv_grant;
  assign bht_acc = (state_q == INV) && !bht_fin_q && bht_inv_grant;

  always_comb begin
    state_d   = state_q;
    ic_cnt_d  = ic_cnt_q;
    bht_cnt_d = bht_cnt_q;
    ic_fin_d  = ic_fin_q;
    bht_fin_d = bht_fin_q;
    done_d    = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (ifu_cp0_rst_inv_req) begin
          state_d   = INV;
          ic_cnt_d  = '0;
          bht_cnt_d = '0;
          ic_fin_d  = 1'b0;
          bht_fin_d = 1'b0;
          done_d    = 1'b0;
        end
      end
      INV: begin
        // The counter parks on the last index rather than wrapping.
        if (ic_acc) begin
          if (&ic_cnt_q) ic_fin_d = 1'b1;
          else           ic_cnt_d = ic_cnt_q + IC_IDX_W'(1);
        end
        if (bht_acc) begin
          if (&bht_cnt_q) bht_fin_d = 1'b1;
          else            bht_cnt_d = bht_cnt_q + BHT_IDX_W'(1);
        end
        // Leave on the edge of the final accepted write so done rises the next cycle.
        if (ic_fin_d && bht_fin_d) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= IDLE;
      ic_cnt_q  <= '0;
      bht_cnt_q <= '0;
      ic_fin_q  <= 1'b0;
      bht_fin_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ic_cnt_q  <= ic_cnt_d;
      bht_cnt_q <= bht_cnt_d;
      ic_fin_q  <= ic_fin_d;
      bht_fin_q <= bht_fin_d;
      done_q    <= done_d;
    end
  end

  assign inv_busy             = (state_q == INV);
  assign inv_icache_tag_req   = (state_q == INV) && !ic_fin_q;
  assign inv_bht_req          = (state_q == INV) && !bht_fin_q;
  assign inv_icache_idx       = ic_cnt_q;
  assign inv_bht_idx          = bht_cnt_q;
  assign cp0_ifu_rst_inv_done = done_q;

endmodule

// File: tb/tb_ct_ifu_rst_inv_seq.sv
// Randomized bench for ct_ifu_rst_inv_seq, checked cycle by cycle against a
// model that tracks only "next index to write" per array and a phase number.
module tb_ct_ifu_rst_inv_seq;

  localparam int IC_IDX_W  = 8;
  localparam int BHT_IDX_W = 10;
  localparam int IC_N      = 1 << IC_IDX_W;
  localparam int BHT_N     = 1 << BHT_IDX_W;

  logic                 clk = 1'b0;
  logic                 cpurst_b;
  logic                 req;
  logic                 icGrant;
  logic                 bhtGrant;
  logic                 icReq;
  logic [IC_IDX_W-1:0]  icIdx;
  logic                 bhtReq;
  logic [BHT_IDX_W-1:0] bhtIdx;
  logic                 done;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 idle, 1 walking, 2 done; next index still to be written.
  int mPhase;
  int mIcNext;
  int mBhtNext;

  always #5 clk = ~clk;

  ct_ifu_rst_inv_seq #(.IC_IDX_W(IC_IDX_W), .BHT_IDX_W(BHT_IDX_W)) dut (
    .forever_cpuclk       (clk),
    .cpurst_b             (cpurst_b),
    .ifu_cp0_rst_inv_req  (req),
    .icache_inv_grant     (icGrant),
    .bht_inv_grant        (bhtGrant),
    .inv_icache_tag_req   (icReq),
    .inv_icache_idx       (icIdx),
    .inv_bht_req          (bhtReq),
    .inv_bht_idx          (bhtIdx),
    .cp0_ifu_rst_inv_done (done),
    .inv_busy             (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    logic expIcReq, expBhtReq;
    expIcReq  = (mPhase == 1) && (mIcNext < IC_N);
    expBhtReq = (mPhase == 1) && (mBhtNext < BHT_N);
    checkOutput("icReq", 32'(icReq), 32'(expIcReq));
    checkOutput("bhtReq", 32'(bhtReq), 32'(expBhtReq));
    checkOutput("busy", 32'(busy), 32'(mPhase == 1));
    checkOutput("done", 32'(done), 32'(mPhase == 2));
    if (expIcReq)  checkOutput("icIdx", 32'(icIdx), 32'(mIcNext));
    if (expBhtReq) checkOutput("bhtIdx", 32'(bhtIdx), 32'(mBhtNext));
  endtask

  task automatic modelReset();
    mPhase   = 0;
    mIcNext  = 0;
    mBhtNext = 0;
  endtask

  // Check this cycle, drive its inputs, and advance the model over the edge.
  task automatic applyStimulus(input logic r, input logic ig, input logic bg);
    compareAll();
    req      = r;
    icGrant  = ig;
    bhtGrant = bg;
    @(posedge clk);
    #1;
    if (mPhase == 1) begin
      if (ig && mIcNext < IC_N)  mIcNext++;
      if (bg && mBhtNext < BHT_N) mBhtNext++;
      if (mIcNext >= IC_N && mBhtNext >= BHT_N) mPhase = 2;
    end else if (r) begin
      mPhase   = 1;
      mIcNext  = 0;
      mBhtNext = 0;
    end
    @(negedge clk);
  endtask

  task automatic resetNow(input string tag);
    cpurst_b = 1'b0;
    req      = 1'b0;
    #1;
    modelReset();
    compareAll();
    checkOutput({tag, " icIdx"}, 32'(icIdx), 0);
    checkOutput({tag, " bhtIdx"}, 32'(bhtIdx), 0);
    @(negedge clk);
    compareAll();
    cpurst_b = 1'b1;
    @(negedge clk);
  endtask

  // Pulse req at edge 0, then walk; expDone < 0 means only the model judges timing.
  task automatic runWalk(input string name, input bit randGrant, input int gapLo, input int gapHi,
                         input int extraReqAt, input int abortAt, input int expDone);
    int doneAt;
    logic ig, bg;
    doneAt = -1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int n = 1; n < 4000; n++) begin
      if (n == abortAt) begin
        resetNow({name, " abort"});
        return;
      end
      if (done === 1'b1) begin
        doneAt = n;
        compareAll();
        break;
      end
      ig = randGrant ? ($urandom_range(0, 3) != 0) : 1'b1;
      bg = randGrant ? ($urandom_range(0, 3) != 0) : !(n >= gapLo && n <= gapHi);
      applyStimulus(n == extraReqAt, ig, bg);
    end
    checkOutput({name, " timeout"}, 32'(doneAt < 0), 0);
    if (expDone > 0) checkOutput({name, " doneCycle"}, doneAt, expDone);
  endtask

  initial begin
    cpurst_b = 1'b0;
    req      = 1'b0;
    icGrant  = 1'b0;
    bhtGrant = 1'b0;
    @(negedge clk);
    resetNow("initRst");
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);

    $display("[TB] full-grant walk");
    runWalk("full", 1'b0, -1, -1, -1, -1, BHT_N + 1);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);

    $display("[TB] restart from DONE with stray req mid-walk");
    runWalk("restart", 1'b0, -1, -1, 500, -1, BHT_N + 1);

    $display("[TB] BHT grant gap");
    runWalk("gap", 1'b0, 10, 19, -1, -1, BHT_N + 11);

    $display("[TB] random grants");
    runWalk("rand1", 1'b1, -1, -1, -1, -1, -1);

    $display("[TB] reset mid-walk");
    runWalk("abort", 1'b0, -1, -1, -1, 300, -1);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b1);
    runWalk("afterRst", 1'b0, -1, -1, -1, -1, BHT_N + 1);

    runWalk("rand2", 1'b1, -1, -1, 200, -1, -1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
